mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle timing with a FETCH/DECODE/EXEC/MEM/WB state machine, gating every architectural write enable (PC, IR, register file, data memory) so the datapath takes one phase per clock. It sits beside the combinational decoder: that decoder keeps producing ALUOp/ALUSrc/EXTOp/GPRSel/WDSel, and `mc_ctrl` decides when results are committed. It also sequences memory handshakes and counts retired instructions.

---
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Bus between the multi-cycle controller and the MIPS datapath: decoded
// instruction fields and flags in, phase-gated write enables and status out.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_rdy;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       MemWrite;
  logic             MemReq;
  logic             IorD;
  logic [1:0]       NPCOp;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    output Op, Funct, Zero, mem_rdy,
    input  PCWrite, IRWrite, RegWrite, MemWrite, MemReq, IorD, NPCOp,
           state, illegal, instret
  );

  modport slave (
    input  Op, Funct, Zero, mem_rdy,
    output PCWrite, IRWrite, RegWrite, MemWrite, MemReq, IorD, NPCOp,
           state, illegal, instret
  );
endinterface

// File: rtl/mc_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer gating the datapath write enables.
// Optional macro MC_WAIT_EN: honour mem_rdy wait states in FETCH and MEM.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_LINK, C_ILL
  } iclass_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  iclass_t          w_class;
  logic [1:0]       w_stype;
  logic             w_is_bne;
  logic             w_taken;
  logic             w_rdy;
  logic             w_retire;
  logic             w_pcwrite, w_irwrite, w_regwrite, w_memreq, w_iord, w_illegal;
  logic [1:0]       w_memwrite, w_npcop;

`ifdef MC_WAIT_EN
  assign w_rdy = bus.mem_rdy;
`else
  // Port kept for a uniform interface; every access completes in one cycle.
  logic w_unused_mem_rdy;
  assign w_unused_mem_rdy = bus.mem_rdy;
  assign w_rdy = 1'b1;
`endif

  always_comb begin
    w_class  = C_ILL;
    w_stype  = 2'b00;
    w_is_bne = 1'b0;
    case (bus.Op)
      6'b000000: begin
        case (bus.Funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100111, 6'b100110,
          6'b101010, 6'b101011, 6'b000000, 6'b000010,
          6'b000011, 6'b000100, 6'b000110, 6'b000111: w_class = C_ALU;
          default:                                    w_class = C_ILL;
        endcase
      end
      6'b001000, 6'b001101, 6'b001100, 6'b001010, 6'b001111: w_class = C_ALU;
      6'b100011, 6'b100000, 6'b100001, 6'b100100, 6'b100101: w_class = C_LOAD;
      6'b101011: begin w_class = C_STORE; w_stype = 2'b01; end
      6'b101000: begin w_class = C_STORE; w_stype = 2'b10; end
      6'b101001: begin w_class = C_STORE; w_stype = 2'b11; end
      6'b000100: w_class = C_BRANCH;
      6'b000101: begin w_class = C_BRANCH; w_is_bne = 1'b1; end
      6'b000010: w_class = C_JUMP;
      6'b000011: w_class = C_LINK;
      default:   w_class = C_ILL;
    endcase
  end

  assign w_taken = w_is_bne ? ~bus.Zero : bus.Zero;

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 2'b00;
    w_memreq   = 1'b0;
    w_iord     = 1'b0;
    w_npcop    = 2'b00;
    w_illegal  = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memreq = 1'b1;
        if (w_rdy) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_class)
          C_JUMP: begin
            w_pcwrite = 1'b1;
            w_npcop   = 2'b10;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
          end
          C_LINK: begin
            w_pcwrite = 1'b1;
            w_npcop   = 2'b10;
            w_next    = S_WB;
          end
          C_ILL: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_class)
          C_BRANCH: begin
            w_pcwrite = w_taken;
            w_npcop   = w_taken ? 2'b01 : 2'b00;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
          end
          C_LOAD, C_STORE: w_next = S_MEM;
          default:         w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_memreq   = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = (w_class == C_STORE) ? w_stype : 2'b00;
        if (w_rdy) begin
          w_retire = (w_class == C_STORE);
          w_next   = (w_class == C_STORE) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset overrides memory handshakes and flags: nothing commits this cycle.
    if (rst) begin
      w_next     = S_FETCH;
      w_pcwrite  = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 2'b00;
      w_memreq   = 1'b0;
      w_iord     = 1'b0;
      w_npcop    = 2'b00;
      w_illegal  = 1'b0;
      w_retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  assign bus.PCWrite  = w_pcwrite;
  assign bus.IRWrite  = w_irwrite;
  assign bus.RegWrite = w_regwrite;
  assign bus.MemWrite = w_memwrite;
  assign bus.MemReq   = w_memreq;
  assign bus.IorD     = w_iord;
  assign bus.NPCOp    = w_npcop;
  assign bus.state    = r_state;
  assign bus.illegal  = w_illegal;
  assign bus.instret  = r_instret;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations queued from the
// instruction path table, then drained against a 32-bit and a 3-bit counter DUT.
module tb_mc_ctrl;
`ifdef MC_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  st;
    logic        pcw, irw, regw;
    logic [1:0]  mw;
    logic        mreq, iord;
    logic [1:0]  npc;
    logic        ill;
    logic        rdy;
    logic        rst;
    logic [31:0] instret;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, mem_rdy;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  string      tag;
  logic [31:0] exp_instret = '0;
  exp_t       sb[$];

  mc_ctrl_if #(.CNT_W(32)) bus ();
  mc_ctrl_if #(.CNT_W(3))  wbus ();

  assign bus.Op = Op;        assign wbus.Op = Op;
  assign bus.Funct = Funct;  assign wbus.Funct = Funct;
  assign bus.Zero = Zero;    assign wbus.Zero = Zero;
  assign bus.mem_rdy = mem_rdy; assign wbus.mem_rdy = mem_rdy;

  mc_ctrl #(.CNT_W(32)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mc_ctrl #(.CNT_W(3))  u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic [2:0] st, logic pcw, logic irw, logic regw,
                              logic [1:0] mw, logic mreq, logic iord,
                              logic [1:0] npc, logic ill, logic rdy, logic r);
    exp_t e;
    e.st = st; e.pcw = pcw; e.irw = irw; e.regw = regw; e.mw = mw;
    e.mreq = mreq; e.iord = iord; e.npc = npc; e.ill = ill;
    e.rdy = rdy; e.rst = r; e.instret = exp_instret;
    return e;
  endfunction

  task automatic drain();
    exp_t e;
    logic [13:0] a, x;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rst = e.rst;
      mem_rdy = e.rdy;
      @(negedge clk);
      a = {bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
           bus.MemReq, bus.IorD, bus.NPCOp, bus.illegal};
      x = {e.st, e.pcw, e.irw, e.regw, e.mw, e.mreq, e.iord, e.npc, e.ill};
      checks++;
      assert (a === x) else begin
        errors++;
        $error("FAIL %s cyc%0d ctl act=%h exp=%h", tag, cyc, a, x);
      end
      checks++;
      assert (bus.instret === e.instret) else begin
        errors++;
        $error("FAIL %s cyc%0d instret act=%0d exp=%0d", tag, cyc, bus.instret, e.instret);
      end
      checks++;
      assert (wbus.instret === e.instret[2:0]) else begin
        errors++;
        $error("FAIL %s cyc%0d instret3 act=%0d exp=%0d", tag, cyc, wbus.instret, e.instret[2:0]);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // k: 0 ALU, 1 load, 2 store, 3 branch, 4 j, 5 jal, 6 illegal
  task automatic push_fetch(int fw);
    if (WAIT_EN)
      for (int i = 0; i < fw; i++) sb.push_back(mk(3'd0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0));
    sb.push_back(mk(3'd0, 1, 1, 0, 2'b00, 1, 0, 2'b00, 0, (WAIT_EN || fw == 0), 0));
  endtask

  task automatic run_instr(string nm, logic [5:0] op, logic [5:0] fn, logic z,
                           int k, int fw, int mwait, logic [1:0] stype, logic taken);
    tag = nm; Op = op; Funct = fn; Zero = z;
    push_fetch(fw);
    if (k == 4 || k == 5) begin
      sb.push_back(mk(3'd1, 1, 0, 0, 2'b00, 0, 0, 2'b10, 0, 0, 0));
      if (k == 4) exp_instret++;
    end else if (k == 6) begin
      sb.push_back(mk(3'd1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0));
    end else begin
      sb.push_back(mk(3'd1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0));
      sb.push_back(mk(3'd2, taken, 0, 0, 2'b00, 0, 0, taken ? 2'b01 : 2'b00, 0, 0, 0));
      if (k == 3) exp_instret++;
    end
    if (k == 1 || k == 2) begin
      if (WAIT_EN)
        for (int i = 0; i < mwait; i++)
          sb.push_back(mk(3'd3, 0, 0, 0, (k == 2) ? stype : 2'b00, 1, 1, 2'b00, 0, 0, 0));
      sb.push_back(mk(3'd3, 0, 0, 0, (k == 2) ? stype : 2'b00, 1, 1, 2'b00, 0,
                      (WAIT_EN || mwait == 0), 0));
      if (k == 2) exp_instret++;
    end
    if (k == 0 || k == 1 || k == 5) begin
      sb.push_back(mk(3'd4, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0));
      exp_instret++;
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; mem_rdy = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    @(posedge clk); #1;
    tag = "reset";
    sb.push_back(mk(3'd0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 1));
    drain();

    run_instr("addu",    6'b000000, 6'b100001, 1'b0, 0, 0, 0, 2'b00, 1'b0);
    run_instr("lw_wait", 6'b100011, 6'b000000, 1'b0, 1, 0, 3, 2'b00, 1'b0);
    run_instr("sh",      6'b101001, 6'b000000, 1'b0, 2, 1, 0, 2'b11, 1'b0);
    run_instr("beq_t",   6'b000100, 6'b000000, 1'b1, 3, 0, 0, 2'b00, 1'b1);
    run_instr("bne_nt",  6'b000101, 6'b000000, 1'b1, 3, 0, 0, 2'b00, 1'b0);
    run_instr("jal",     6'b000011, 6'b000000, 1'b0, 5, 0, 0, 2'b00, 1'b0);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 6, 0, 0, 2'b00, 1'b0);
    run_instr("ill_fn",  6'b000000, 6'b001000, 1'b0, 6, 0, 0, 2'b00, 1'b0);
    run_instr("ori",     6'b001101, 6'b000000, 1'b0, 0, 2, 0, 2'b00, 1'b0);
    run_instr("j",       6'b000010, 6'b000000, 1'b0, 4, 0, 0, 2'b00, 1'b0);
    run_instr("sb",      6'b101000, 6'b000000, 1'b0, 2, 0, 1, 2'b10, 1'b0);
    run_instr("beq_nt",  6'b000100, 6'b000000, 1'b0, 3, 0, 0, 2'b00, 1'b0);
    run_instr("bne_t",   6'b000101, 6'b000000, 1'b0, 3, 0, 0, 2'b00, 1'b1);
    run_instr("lbu",     6'b100100, 6'b000000, 1'b0, 1, 0, 0, 2'b00, 1'b0);
    run_instr("sra",     6'b000000, 6'b000011, 1'b0, 0, 0, 0, 2'b00, 1'b0);

    // sw interrupted by reset in MEM with mem_rdy high
    tag = "sw_rst"; Op = 6'b101011; Funct = '0; Zero = 1'b0;
    push_fetch(0);
    sb.push_back(mk(3'd1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    sb.push_back(mk(3'd2, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    sb.push_back(mk(3'd3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 1));
    exp_instret = '0;
    drain();

    run_instr("addu_2",  6'b000000, 6'b100001, 1'b0, 0, 0, 0, 2'b00, 1'b0);
    run_instr("sw",      6'b101011, 6'b000000, 1'b0, 2, 0, 0, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
